// File: rtl/aline_trigger_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : aline_trigger_pkg
//  Purpose  : Shared constants and state type for the A-line trigger
//             sequencer: interval-timer register map, control words and the
//             sequencer state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package aline_trigger_pkg;

    // Interval timer register addresses (16-bit register variant)
    localparam logic [2:0] c_ADDR_STATUS  = 3'd0;
    localparam logic [2:0] c_ADDR_CONTROL = 3'd1;
    localparam logic [2:0] c_ADDR_PERIODL = 3'd2;
    localparam logic [2:0] c_ADDR_PERIODH = 3'd3;
    localparam logic [2:0] c_ADDR_SNAPL   = 3'd4;
    localparam logic [2:0] c_ADDR_SNAPH   = 3'd5;

    // Control register bit positions
    localparam int c_CTRL_ITO_BIT   = 0;
    localparam int c_CTRL_CONT_BIT  = 1;
    localparam int c_CTRL_START_BIT = 2;
    localparam int c_CTRL_STOP_BIT  = 3;

    // Start continuous with interrupt enabled; stop with interrupt masked
    localparam logic [15:0] c_CTRL_RUN  = (16'd1 << c_CTRL_START_BIT)
                                        | (16'd1 << c_CTRL_CONT_BIT)
                                        | (16'd1 << c_CTRL_ITO_BIT);
    localparam logic [15:0] c_CTRL_HALT = (16'd1 << c_CTRL_STOP_BIT);

    // Default lower bound on the accepted period value
    localparam int c_MIN_PERIOD_DEFAULT = 8;

    // Sequencer states; the SNAP_* states are only entered when the
    // snapshot option is compiled in
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_CLR      = 4'd1,
        S_WR_PL    = 4'd2,
        S_WR_PH    = 4'd3,
        S_WR_CTRL  = 4'd4,
        S_RUN      = 4'd5,
        S_ACK      = 4'd6,
        S_STOP     = 4'd7,
        S_SNAP_WR  = 4'd8,
        S_SNAP_RL  = 4'd9,
        S_SNAP_RH  = 4'd10,
        S_SNAP_CAP = 4'd11
    } ats_state_t;

endpackage : aline_trigger_pkg
`default_nettype wire

// File: rtl/aline_snap_reader.sv
`default_nettype none
// ============================================================================
//  Module   : aline_snap_reader
//  Purpose  : Residual-count snapshot of the interval timer after a stop.
//             Drives the timer bus during the SNAP_* states (latch, read low,
//             read high) and assembles the 32-bit snapshot value.
//             Only present when ATS_SNAPSHOT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`ifdef ATS_SNAPSHOT_EN
module aline_snap_reader
    import aline_trigger_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  ats_state_t  i_state,
    input  logic [15:0] i_readdata,
    output logic        o_chipselect,
    output logic        o_write_n,
    output logic [2:0]  o_address,
    output logic [15:0] o_writedata,
    output logic [31:0] o_snap_value,
    output logic        o_snap_valid
);

    logic [31:0] r_snap_value;
    logic        r_snap_valid;

    // Bus decode for the snapshot states; idle values elsewhere
    always_comb begin
        o_chipselect = 1'b0;
        o_write_n    = 1'b1;
        o_address    = 3'd0;
        o_writedata  = 16'd0;
        case (i_state)
            S_SNAP_WR: begin
                o_chipselect = 1'b1;
                o_write_n    = 1'b0;
                o_address    = c_ADDR_SNAPL;
            end
            S_SNAP_RL: begin
                o_chipselect = 1'b1;
                o_address    = c_ADDR_SNAPL;
            end
            S_SNAP_RH: begin
                o_chipselect = 1'b1;
                o_address    = c_ADDR_SNAPH;
            end
            default: ;
        endcase
    end

    // Registered slave: read data lags the address by one cycle, so the low
    // half arrives in SNAP_RH and the high half in SNAP_CAP
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_snap_value <= 32'd0;
            r_snap_valid <= 1'b0;
        end else begin
            r_snap_valid <= 1'b0;
            if (i_state == S_SNAP_RH) begin
                r_snap_value[15:0] <= i_readdata;
            end
            if (i_state == S_SNAP_CAP) begin
                r_snap_value[31:16] <= i_readdata;
                r_snap_valid        <= 1'b1;
            end
        end
    end

    assign o_snap_value = r_snap_value;
    assign o_snap_valid = r_snap_valid;

endmodule : aline_snap_reader
`endif
`default_nettype wire

// File: rtl/aline_trigger_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : aline_trigger_sequencer
//  Purpose  : Avalon-MM master owning the interval timer. Programs the
//             period, runs the timer continuously, converts each timer IRQ
//             into one A-line trigger pulse and stops after n_sweeps
//             triggers (0 = until abort) or on abort.
//  Options  : ATS_SNAPSHOT_EN - after stopping, snapshot and read back the
//             residual timer count (adds snap_value / snap_valid).
//  Revision : 1.0  initial release
// ============================================================================
module aline_trigger_sequencer
    import aline_trigger_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int MIN_PERIOD = c_MIN_PERIOD_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      period,
    input  logic [CNT_W-1:0] n_sweeps,
    output logic             busy,
    output logic             trig,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] sweep_idx,
    output logic [2:0]       tmr_address,
    output logic             tmr_chipselect,
    output logic             tmr_write_n,
    output logic [15:0]      tmr_writedata,
    input  logic [15:0]      tmr_readdata,
    input  logic             tmr_irq
`ifdef ATS_SNAPSHOT_EN
    ,
    output logic [31:0]      snap_value,
    output logic             snap_valid
`endif
);

    ats_state_t       r_state;
    logic [31:0]      r_period;
    logic [CNT_W-1:0] r_n_sweeps;
    logic [CNT_W-1:0] r_sweep_idx;
    logic             r_done;
    logic             r_err;

    logic             w_period_ok;
    logic [CNT_W-1:0] w_idx_next;
    logic             w_last_sweep;

    assign w_period_ok  = (period >= 32'(MIN_PERIOD));
    assign w_idx_next   = r_sweep_idx + 1'b1;
    assign w_last_sweep = (r_n_sweeps != '0) && (w_idx_next == r_n_sweeps);

    // Sequencer FSM: setup writes, IRQ service loop, stop and done/err pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_period    <= 32'd0;
            r_n_sweeps  <= '0;
            r_sweep_idx <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_period_ok) begin
                            r_period    <= period;
                            r_n_sweeps  <= n_sweeps;
                            r_sweep_idx <= '0;
                            r_state     <= S_CLR;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_CLR:     r_state <= S_WR_PL;
                S_WR_PL:   r_state <= S_WR_PH;
                S_WR_PH:   r_state <= S_WR_CTRL;
                S_WR_CTRL: r_state <= S_RUN;
                S_RUN: begin
                    // abort has priority over a coincident IRQ; the pending
                    // timeout is masked by the stop word and cleared by CLR
                    if (abort) begin
                        r_state <= S_STOP;
                    end else if (tmr_irq) begin
                        r_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    r_sweep_idx <= w_idx_next;
                    if (w_last_sweep || abort) begin
                        r_state <= S_STOP;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
`ifdef ATS_SNAPSHOT_EN
                S_STOP:     r_state <= S_SNAP_WR;
                S_SNAP_WR:  r_state <= S_SNAP_RL;
                S_SNAP_RL:  r_state <= S_SNAP_RH;
                S_SNAP_RH:  r_state <= S_SNAP_CAP;
                S_SNAP_CAP: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                end
`else
                S_STOP: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ATS_SNAPSHOT_EN
    logic        w_snap_cs;
    logic        w_snap_write_n;
    logic [2:0]  w_snap_address;
    logic [15:0] w_snap_writedata;

    aline_snap_reader u_snap_reader (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_state      (r_state),
        .i_readdata   (tmr_readdata),
        .o_chipselect (w_snap_cs),
        .o_write_n    (w_snap_write_n),
        .o_address    (w_snap_address),
        .o_writedata  (w_snap_writedata),
        .o_snap_value (snap_value),
        .o_snap_valid (snap_valid)
    );
`else
    // Read data is only consumed by the snapshot option
    logic w_unused_readdata;
    assign w_unused_readdata = ^tmr_readdata;
`endif

    // Timer bus decoded from the registered state
    always_comb begin
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_address    = 3'd0;
        tmr_writedata  = 16'd0;
        case (r_state)
            S_CLR, S_ACK: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = c_ADDR_STATUS;
            end
            S_WR_PL: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = c_ADDR_PERIODL;
                tmr_writedata  = r_period[15:0];
            end
            S_WR_PH: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = c_ADDR_PERIODH;
                tmr_writedata  = r_period[31:16];
            end
            S_WR_CTRL: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = c_ADDR_CONTROL;
                tmr_writedata  = c_CTRL_RUN;
            end
            S_STOP: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = c_ADDR_CONTROL;
                tmr_writedata  = c_CTRL_HALT;
            end
            default: ;
        endcase
`ifdef ATS_SNAPSHOT_EN
        if (w_snap_cs) begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = w_snap_write_n;
            tmr_address    = w_snap_address;
            tmr_writedata  = w_snap_writedata;
        end
`endif
    end

    assign busy      = (r_state != S_IDLE);
    assign trig      = (r_state == S_ACK);
    assign done      = r_done;
    assign err       = r_err;
    assign sweep_idx = r_sweep_idx;

endmodule : aline_trigger_sequencer
`default_nettype wire

// File: tb/tb_aline_trigger_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aline_trigger_sequencer
//  Purpose  : Directed bench for aline_trigger_sequencer with a behavioural
//             interval-timer model on the Avalon side.
//  Options  : ATS_SNAPSHOT_EN - also exercises the residual-count snapshot.
//  Revision : 1.0  initial release
// ============================================================================
module tb_aline_trigger_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [31:0] period;
    logic [15:0] n_sweeps;
    logic        busy;
    logic        trig;
    logic        done;
    logic        err;
    logic [15:0] sweep_idx;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic [15:0] tmr_readdata;
    logic        tmr_irq;
`ifdef ATS_SNAPSHOT_EN
    logic [31:0] snap_value;
    logic        snap_valid;
`endif

    aline_trigger_sequencer #(
        .CNT_W      (16),
        .MIN_PERIOD (8)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .period         (period),
        .n_sweeps       (n_sweeps),
        .busy           (busy),
        .trig           (trig),
        .done           (done),
        .err            (err),
        .sweep_idx      (sweep_idx),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_readdata   (tmr_readdata),
        .tmr_irq        (tmr_irq)
`ifdef ATS_SNAPSHOT_EN
        ,
        .snap_value     (snap_value),
        .snap_valid     (snap_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- interval timer model ----------------
    logic [15:0] t_pl, t_ph, t_snl, t_snh;
    logic [31:0] t_cnt;
    logic        t_run, t_ito, t_to;

    // Counts down from the period; reaching zero sets timeout and reloads
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_pl <= 16'd0; t_ph <= 16'd0; t_snl <= 16'd0; t_snh <= 16'd0;
            t_cnt <= 32'd0; t_run <= 1'b0; t_ito <= 1'b0; t_to <= 1'b0;
            tmr_readdata <= 16'd0;
        end else begin
            if (t_run) begin
                if (t_cnt == 32'd0) begin
                    t_to  <= 1'b1;
                    t_cnt <= {t_ph, t_pl};
                end else begin
                    t_cnt <= t_cnt - 32'd1;
                end
            end
            if (tmr_chipselect && !tmr_write_n) begin
                case (tmr_address)
                    3'd0: t_to <= 1'b0;
                    3'd1: begin
                        t_ito <= tmr_writedata[0];
                        if (tmr_writedata[2]) begin
                            t_run <= 1'b1;
                            t_cnt <= {t_ph, t_pl};
                        end
                        if (tmr_writedata[3]) t_run <= 1'b0;
                    end
                    3'd2: t_pl <= tmr_writedata;
                    3'd3: t_ph <= tmr_writedata;
                    3'd4: {t_snh, t_snl} <= t_cnt;
                    default: ;
                endcase
            end
            if (tmr_chipselect && tmr_write_n) begin
                tmr_readdata <= (tmr_address == 3'd4) ? t_snl :
                                (tmr_address == 3'd5) ? t_snh : 16'd0;
            end
        end
    end
    assign tmr_irq = t_to & t_ito;

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_err = 0;
    int cyc;
    int wa[$], wd[$], wc[$];
    int tc[$], dc[$];
    int sv_cyc[$];
    int err_cnt, bus_cnt, busy_cnt;
    logic busy_at_done;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wa.delete(); wd.delete(); wc.delete();
        tc.delete(); dc.delete(); sv_cyc.delete();
        cyc = 0; err_cnt = 0; bus_cnt = 0; busy_cnt = 0; busy_at_done = 1'b1;
    endtask

    // Advance one cycle and record what the DUT shows mid-cycle
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (tmr_chipselect && !tmr_write_n) begin
            wa.push_back(int'(tmr_address));
            wd.push_back(int'(tmr_writedata));
            wc.push_back(cyc);
        end
        if (tmr_chipselect) bus_cnt++;
        if (busy) busy_cnt++;
        if (trig) tc.push_back(cyc);
        if (err) err_cnt++;
        if (done) begin
            dc.push_back(cyc);
            busy_at_done = busy;
        end
`ifdef ATS_SNAPSHOT_EN
        if (snap_valid) sv_cyc.push_back(cyc);
`endif
    endtask

    // Request sampled at the next edge; that request cycle is cycle 0
    task automatic do_start(input int p, input int n);
        start = 1'b1; period = p; n_sweeps = 16'(n);
        clear_logs();
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (dc.size() == 0 && k < budget) begin tick(); k++; end
        check_val("done_within_budget", dc.size() > 0, 1);
    endtask

    task automatic wait_trigs(input int n, input int budget);
        int k = 0;
        while (tc.size() < n && k < budget) begin tick(); k++; end
        check_val("trigs_within_budget", tc.size() >= n, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        int ntr;
        int nidx;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; period = 32'd0; n_sweeps = 16'd0;
        clear_logs();
        tick(); tick();

        // ---- reset values ----
        check_val("rst_busy", busy, 0);
        check_val("rst_trig", trig, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err", err, 0);
        check_val("rst_sweep_idx", sweep_idx, 0);
        check_val("rst_cs", tmr_chipselect, 0);
        check_val("rst_write_n", tmr_write_n, 1);
        check_val("rst_addr", tmr_address, 0);
        check_val("rst_wdata", tmr_writedata, 0);
        reset_n = 1'b1;
        tick(); tick();

        // ---- period=99, three sweeps ----
        do_start(99, 3);
        repeat (49) tick();
        start = 1'b1; period = 32'd5;          // ignored while busy
        tick();
        start = 1'b0; period = 32'd99;
        wait_done(1000);
        tick(); tick();
        check_val("t1_w0_addr", wa[0], 0);  check_val("t1_w0_data", wd[0], 0);  check_val("t1_w0_cyc", wc[0], 1);
        check_val("t1_w1_addr", wa[1], 2);  check_val("t1_w1_data", wd[1], 99); check_val("t1_w1_cyc", wc[1], 2);
        check_val("t1_w2_addr", wa[2], 3);  check_val("t1_w2_data", wd[2], 0);  check_val("t1_w2_cyc", wc[2], 3);
        check_val("t1_w3_addr", wa[3], 1);  check_val("t1_w3_data", wd[3], 7);  check_val("t1_w3_cyc", wc[3], 4);
        check_val("t1_trig_count", tc.size(), 3);
        check_val("t1_first_trig", tc[0], 106);
        check_val("t1_spacing_a", tc[1] - tc[0], 100);
        check_val("t1_spacing_b", tc[2] - tc[1], 100);
        check_val("t1_ack_addr", wa[4], 0);
        check_val("t1_ack_cyc", wc[4], 106);
        check_val("t1_stop_addr", wa[7], 1);
        check_val("t1_stop_data", wd[7], 8);
        check_val("t1_stop_cyc", wc[7], 307);
        check_val("t1_write_count", wa.size(), 8);
        check_val("t1_done_count", dc.size(), 1);
        check_val("t1_done_cyc", dc[0], 308);
        check_val("t1_busy_at_done", busy_at_done, 0);
        check_val("t1_sweep_idx", sweep_idx, 3);
        check_val("t1_err_while_busy", err_cnt, 0);

        // ---- period below minimum ----
        do_start(5, 3);
        repeat (4) tick();
        check_val("t2_err_count", err_cnt, 1);
        check_val("t2_bus_cycles", bus_cnt, 0);
        check_val("t2_busy_cycles", busy_cnt, 0);
        check_val("t2_sweep_idx_kept", sweep_idx, 3);

        // ---- period exactly at minimum is accepted ----
        do_start(8, 1);
        wait_done(100);
        check_val("t2b_err", err_cnt, 0);
        check_val("t2b_trigs", tc.size(), 1);
        check_val("t2b_first_trig", tc[0], 15);

        // ---- continuous, abort after ten triggers ----
        do_start(15, 0);
        wait_trigs(10, 400);
        tick();
        abort = 1'b1;
        k = cyc;
        tick();
        abort = 1'b0;
        check_val("t3_stop_addr", wa[wa.size()-1], 1);
        check_val("t3_stop_data", wd[wd.size()-1], 8);
        check_val("t3_stop_cyc", wc[wc.size()-1], k + 1);
        wait_done(20);
        check_val("t3_trig_count", tc.size(), 10);
        check_val("t3_spacing_first", tc[1] - tc[0], 16);
        check_val("t3_spacing_last", tc[9] - tc[8], 16);
        check_val("t3_sweep_idx", sweep_idx, 10);

        // ---- abort coincident with IRQ ----
        do_start(15, 0);
        wait_trigs(1, 100);
        tick();
        k = 0;
        while (!tmr_irq && k < 100) begin tick(); k++; end
        check_val("t4_irq_seen", tmr_irq, 1);
        abort = 1'b1;
        ntr = tc.size();
        nidx = int'(sweep_idx);
        tick();
        abort = 1'b0;
        check_val("t4_no_trig", tc.size(), ntr);
        check_val("t4_stop_data", wd[wd.size()-1], 8);
        check_val("t4_stop_addr", wa[wa.size()-1], 1);
        wait_done(20);
        check_val("t4_sweep_idx", sweep_idx, nidx);
        check_val("t4_sweep_idx_abs", sweep_idx, 1);
        do_start(20, 1);
        check_val("t4_restart_addr", wa[0], 0);
        check_val("t4_restart_data", wd[0], 0);
        check_val("t4_restart_cyc", wc[0], 1);
        wait_done(100);
        check_val("t4_restart_trigs", tc.size(), 1);
        check_val("t4_restart_first", tc[0], 27);

        // ---- reset mid-run ----
        do_start(50, 0);
        repeat (70) tick();
        check_val("t5_pre_idx", sweep_idx, 1);
        reset_n = 1'b0;
        #1;
        check_val("t5_busy", busy, 0);
        check_val("t5_cs", tmr_chipselect, 0);
        check_val("t5_write_n", tmr_write_n, 1);
        check_val("t5_trig", trig, 0);
        check_val("t5_sweep_idx", sweep_idx, 0);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        do_start(20, 2);
        wait_done(200);
        check_val("t5_trigs", tc.size(), 2);
        check_val("t5_spacing", tc[1] - tc[0], 21);
        check_val("t5_final_idx", sweep_idx, 2);

`ifdef ATS_SNAPSHOT_EN
        // ---- snapshot of residual count ----
        do_start(1000, 0);
        wait_trigs(1, 1200);
        repeat (300) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done(40);
        check_val("t6_snap_in_range", (snap_value >= 32'd696) && (snap_value <= 32'd704), 1);
        check_val("t6_snap_valid_count", sv_cyc.size(), 1);
        check_val("t6_snap_valid_with_done", sv_cyc[0], dc[0]);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_aline_trigger_sequencer
`default_nettype wire

// File: doc/aline_trigger_sequencer.md
# aline_trigger_sequencer

Avalon-MM master that owns the 16-bit-register interval timer and turns it into a bounded A-line trigger train for the swept-source acquisition path. On a start request it clears and programs the timer's period, starts it in continuous mode with interrupts enabled, then services each timer IRQ by clearing status and issuing one trigger pulse. It stops the timer after a programmed sweep count or on abort. It sits between the acquisition control registers and the timer slave, which it drives exclusively.

## Interface
- CNT_W, 16, width of sweep count and sweep index
- MIN_PERIOD, 8, smallest accepted period value; smaller requests are rejected
- clk  in  1  clock, shared with timer
- reset_n  in  1  reset, asynchronous, active-low; must be the same net that resets the timer
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  level; stops a running train
- period  in  32  timer load value; sampled with start
- n_sweeps  in  CNT_W  triggers to emit; 0 = run until abort; sampled with start
- busy  out  1  high in every state except IDLE
- trig  out  1  one-cycle A-line trigger pulse
- done  out  1  one-cycle pulse on return to IDLE after a started train
- err  out  1  one-cycle pulse when start is rejected
- sweep_idx  out  CNT_W  completed triggers since last accepted start
- tmr_address  out  3  timer register address
- tmr_chipselect  out  1  timer select
- tmr_write_n  out  1  active-low write
- tmr_writedata  out  16  timer write data
- tmr_readdata  in  16  timer read data, valid one cycle after address (registered slave)
- tmr_irq  in  1  timer interrupt, level

## Operation
- Timer map used: 0 status (write clears timeout), 1 control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), 2 period_l, 3 period_h, 4/5 snap_l/h.
- States: IDLE, CLR, WR_PL, WR_PH, WR_CTRL, RUN, ACK, STOP, then the snapshot states when compiled in.
- IDLE: start with period >= MIN_PERIOD loads period and n_sweeps, clears sweep_idx, and goes to CLR. start with a smaller period pulses err and stays in IDLE.
- Setup writes, one cycle each: CLR writes addr0 = 0. WR_PL writes addr2 = period[15:0]. WR_PH writes addr3 = period[31:16]. WR_CTRL writes addr1 = 0x0007 (START|CONT|ITO). Then RUN.
- RUN: abort goes to STOP. tmr_irq goes to ACK.
- ACK: writes addr0, pulses trig, and increments sweep_idx. If n_sweeps != 0 and the new sweep_idx == n_sweeps, go to STOP; else go to RUN.
- STOP: writes addr1 = 0x0008 (STOP, ITO cleared), then goes to IDLE and pulses done.
- Simultaneous abort and tmr_irq in RUN: abort wins; no trig, no increment. The pending timeout is masked by ITO=0 and cleared by the next CLR.
- abort in ACK: the ACK completes, then STOP. abort outside RUN/ACK is ignored.
- start while busy is ignored. sweep_idx wraps modulo 2^CNT_W when n_sweeps=0.
- Bus outputs are decoded from the registered state. Idle bus values: chipselect=0, write_n=1, address=0, writedata=0.
- Reset values: every output 0 except tmr_write_n=1. State = IDLE.

## Timing
- start sampled at cycle 0. CLR, WR_PL, WR_PH, WR_CTRL occupy cycles 1-4. RUN from cycle 5. The timer counts from cycle 5.
- Steady state: trig spacing = period+1 clocks. trig is high in the ACK cycle, one cycle after tmr_irq is first seen high.
- The timer clears its IRQ at the edge ending ACK, so RUN never double-counts.
- Last trigger: STOP occupies the cycle after ACK; done is high the cycle after STOP, with busy already low.
- abort latency: STOP in the cycle after abort is seen in RUN.

## Configuration
- ATS_SNAPSHOT_EN defined:
  - STOP is followed by SNAP_WR (write addr4), SNAP_RL (read addr4), SNAP_RH (read addr5, capture low half), SNAP_CAP (capture high half), then IDLE with done.
  - Adds outputs snap_value (32 bits, residual count at stop, reset 0) and snap_valid (one-cycle pulse, coincident with done).
- Undefined: no snapshot states or ports; STOP goes directly to IDLE.

## Structure
- Package aline_trigger_pkg holds:
  - timer register address constants;
  - control bit positions and the 0x0007/0x0008 control words;
  - the state enum;
  - the MIN_PERIOD default.
- Optional sub-module aline_snap_reader implements the snapshot write/read/capture sequence, instantiated only under ATS_SNAPSHOT_EN.

## Test plan
- period=99, n_sweeps=3, against a timer model: writes addr0=0, 2=99, 3=0, 1=0x0007 in cycles 1-4. Three trig pulses 100 clocks apart. sweep_idx=3. STOP write 0x0008. done once. busy low.
- period=5: err pulse, no bus activity, busy stays 0.
- n_sweeps=0, period=15: continuous triggers. abort after 10 triggers: STOP the next cycle, sweep_idx=10, done.
- abort and tmr_irq asserted in the same RUN cycle: no trig, sweep_idx unchanged, STOP issued. A following start begins with the addr0 clear.
- reset_n low mid-RUN: all outputs return to reset values immediately, and IDLE is reached. start after release runs normally.
- ATS_SNAPSHOT_EN, period=1000, abort 300 clocks after the last trig: snap_value ≈ 700 (±4), snap_valid coincident with done.
